// File: rtl/servant_wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter in front of a single slave port.
// Grants one classic cycle at a time and aborts hung cycles with a watchdog error pulse.
module servant_wb_rr_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [AW-1:0] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_cyc,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  input  logic [AW-1:0] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_cyc,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [AW-1:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_cyc,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack
);

  // Counter is kept at least 1 bit wide so a disabled watchdog still elaborates.
  localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cyc_g;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and the combinational slave/master routing.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    tmo_d    = tmo_q;
    o_s_adr  = '0;
    o_s_dat  = '0;
    o_s_sel  = '0;
    o_s_we   = 1'b0;
    o_s_cyc  = 1'b0;
    o_m0_rdt = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_rdt = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    cyc_g    = gnt_q ? i_m1_cyc : i_m0_cyc;

    case (state_q)
      IDLE: begin
        if (i_m0_cyc || i_m1_cyc) begin
          gnt_d   = (i_m0_cyc && i_m1_cyc) ? ~last_q : i_m1_cyc;
          tmo_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!wb_rst) begin
          o_s_adr = gnt_q ? i_m1_adr : i_m0_adr;
          o_s_dat = gnt_q ? i_m1_dat : i_m0_dat;
          o_s_sel = gnt_q ? i_m1_sel : i_m0_sel;
          o_s_we  = gnt_q ? i_m1_we  : i_m0_we;
          o_s_cyc = cyc_g;
        end
        if (!cyc_g) begin
          // Master abandoned the cycle; any later ack is stale.
          state_d = IDLE;
        end else if (i_s_ack) begin
          o_m0_ack = !wb_rst && !gnt_q;
          o_m1_ack = !wb_rst && gnt_q;
          o_m0_rdt = (!wb_rst && !gnt_q) ? i_s_rdt : '0;
          o_m1_rdt = (!wb_rst && gnt_q) ? i_s_rdt : '0;
          last_d   = gnt_q;
          state_d  = HOLD;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          o_m0_err = !wb_rst && !gnt_q;
          o_m1_err = !wb_rst && gnt_q;
          last_d   = gnt_q;
          state_d  = HOLD;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_servant_wb_rr_arbiter.sv
// Bench for servant_wb_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_servant_wb_rr_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [AW-1:0] i_m0_adr, i_m1_adr;
  logic [31:0]   i_m0_dat, i_m1_dat;
  logic [3:0]    i_m0_sel, i_m1_sel;
  logic          i_m0_we, i_m1_we, i_m0_cyc, i_m1_cyc;
  logic [31:0]   o_m0_rdt, o_m1_rdt;
  logic          o_m0_ack, o_m1_ack, o_m0_err, o_m1_err;
  logic [AW-1:0] o_s_adr;
  logic [31:0]   o_s_dat;
  logic [3:0]    o_s_sel;
  logic          o_s_we, o_s_cyc;
  logic [31:0]   i_s_rdt;
  logic          i_s_ack;

  servant_wb_rr_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_sel(i_m0_sel),
    .i_m0_we(i_m0_we), .i_m0_cyc(i_m0_cyc),
    .o_m0_rdt(o_m0_rdt), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_sel(i_m1_sel),
    .i_m1_we(i_m1_we), .i_m1_cyc(i_m1_cyc),
    .o_m1_rdt(o_m1_rdt), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel),
    .o_s_we(o_s_we), .o_s_cyc(o_s_cyc),
    .i_s_rdt(i_s_rdt), .i_s_ack(i_s_ack)
  );

  always #5 wb_clk = ~wb_clk;

  // Model: which master owns the slave (-1 none), whether we sit in the
  // post-completion gap, how long the owner has waited, who wins next contention.
  int owner = -1;
  bit hold  = 1'b0;
  int age   = 0;
  int pref  = 0;

  int n_chk  = 0;
  int n_fail = 0;
  int got_q[$];
  bit saw_err0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_m0_adr = '0; i_m0_dat = '0; i_m0_sel = '0; i_m0_we = 1'b0; i_m0_cyc = 1'b0;
    i_m1_adr = '0; i_m1_dat = '0; i_m1_sel = '0; i_m1_we = 1'b0; i_m1_cyc = 1'b0;
    i_s_rdt  = '0; i_s_ack  = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, step past the edge.
  task automatic tick();
    logic [31:0] e_adr, e_dat, e_rdt0, e_rdt1;
    logic [3:0]  e_sel;
    logic        e_we, e_cyc, e_ack0, e_ack1, e_err0, e_err1;
    bit          done;
    @(negedge wb_clk);
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0;
    e_rdt0 = '0; e_rdt1 = '0; e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
    done = 1'b0;
    if (!wb_rst && owner >= 0 && !hold) begin
      if (owner == 0) begin
        e_adr = i_m0_adr; e_dat = i_m0_dat; e_sel = i_m0_sel; e_we = i_m0_we; e_cyc = i_m0_cyc;
      end else begin
        e_adr = i_m1_adr; e_dat = i_m1_dat; e_sel = i_m1_sel; e_we = i_m1_we; e_cyc = i_m1_cyc;
      end
      if (e_cyc && i_s_ack) begin
        done = 1'b1;
        if (owner == 0) begin e_ack0 = 1'b1; e_rdt0 = i_s_rdt; end
        else begin e_ack1 = 1'b1; e_rdt1 = i_s_rdt; end
      end else if (e_cyc && age == int'(TO) - 1) begin
        done = 1'b1;
        if (owner == 0) e_err0 = 1'b1; else e_err1 = 1'b1;
      end
    end
    chk("s_adr", 64'(o_s_adr), 64'(e_adr));
    chk("s_dat", 64'(o_s_dat), 64'(e_dat));
    chk("s_sel", 64'(o_s_sel), 64'(e_sel));
    chk("s_we", 64'(o_s_we), 64'(e_we));
    chk("s_cyc", 64'(o_s_cyc), 64'(e_cyc));
    chk("m0_rdt", 64'(o_m0_rdt), 64'(e_rdt0));
    chk("m0_ack", 64'(o_m0_ack), 64'(e_ack0));
    chk("m0_err", 64'(o_m0_err), 64'(e_err0));
    chk("m1_rdt", 64'(o_m1_rdt), 64'(e_rdt1));
    chk("m1_ack", 64'(o_m1_ack), 64'(e_ack1));
    chk("m1_err", 64'(o_m1_err), 64'(e_err1));
    if (o_m0_ack === 1'b1) got_q.push_back(0);
    if (o_m1_ack === 1'b1) got_q.push_back(1);
    saw_err0 = (o_m0_err === 1'b1);
    if (wb_rst) begin
      owner = -1; hold = 1'b0; age = 0; pref = 0;
    end else if (hold) begin
      hold = 1'b0; owner = -1;
    end else if (owner < 0) begin
      if (i_m0_cyc && i_m1_cyc) owner = pref;
      else if (i_m0_cyc) owner = 0;
      else if (i_m1_cyc) owner = 1;
      age = 0;
    end else if (!e_cyc) begin
      owner = -1;
    end else if (done) begin
      pref = 1 - owner; hold = 1'b1;
    end else begin
      age++;
    end
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int err_at;
    int ord;
    clear_inputs();
    wb_rst = 1'b1;
    tick(); tick();
    wb_rst = 1'b0;
    tick();

    // 1: m0 read, slave acks one cycle after cyc
    got_q.delete();
    i_m0_cyc = 1'b1; i_m0_adr = 32'h100; i_m0_sel = 4'hF;
    tick();
    tick();
    i_s_ack = 1'b1; i_s_rdt = 32'hDEADBEEF;
    tick();
    i_s_ack = 1'b0; i_s_rdt = '0; i_m0_cyc = 1'b0;
    tick(); tick();
    chk("t1_acks", 64'(got_q.size()), 64'(1));
    chk("t1_who", 64'(got_q.size() > 0 ? got_q[0] : -1), 64'(0));

    // 2: continuous contention from a fresh reset alternates m0,m1,m0,m1
    wb_rst = 1'b1; tick(); wb_rst = 1'b0;
    got_q.delete();
    i_m0_cyc = 1'b1; i_m0_adr = 32'h200; i_m1_cyc = 1'b1; i_m1_adr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      tick();
      i_s_ack = 1'b1; i_s_rdt = 32'hA000_0000 + 32'(k);
      tick();
      i_s_ack = 1'b0;
      tick();
    end
    clear_inputs();
    tick();
    chk("t2_count", 64'(got_q.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      ord = (got_q.size() > k) ? got_q[k] : -1;
      chk("t2_order", 64'(ord), 64'(k % 2));
    end

    // 3: m1 write with m0 idle
    got_q.delete();
    i_m1_cyc = 1'b1; i_m1_we = 1'b1; i_m1_dat = 32'h12345678; i_m1_sel = 4'hF; i_m1_adr = 32'h44;
    tick();
    tick();
    i_s_ack = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();
    chk("t3_who", 64'(got_q.size() == 1 ? got_q[0] : -1), 64'(1));

    // 4: slave never acks -> m0 error on the TO-th busy cycle, then m1 served
    got_q.delete();
    i_m0_cyc = 1'b1; i_m0_adr = 32'h500; i_m1_cyc = 1'b1; i_m1_adr = 32'h600;
    tick();
    err_at = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (saw_err0) begin err_at = n; break; end
    end
    chk("t4_err_cycle", 64'(err_at), 64'(TO));
    i_m0_cyc = 1'b0;
    tick(); tick();
    i_s_ack = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();
    chk("t4_next_m1", 64'(got_q.size() == 1 ? got_q[0] : -1), 64'(1));

    // 5: reset while busy, then contention goes to m0
    got_q.delete();
    i_m1_cyc = 1'b1;
    tick(); tick();
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0; i_m0_cyc = 1'b1;
    tick();
    i_s_ack = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();
    chk("t5_who", 64'(got_q.size() == 1 ? got_q[0] : -1), 64'(0));

    // 6: m0 aborts, stale ack afterwards must not reach it
    got_q.delete();
    i_m0_cyc = 1'b1; i_m0_adr = 32'h700;
    tick(); tick();
    i_m0_cyc = 1'b0;
    tick();
    i_s_ack = 1'b1;
    tick();
    i_s_ack = 1'b0;
    chk("t6_no_ack", 64'(got_q.size()), 64'(0));
    i_m1_cyc = 1'b1;
    tick();
    i_s_ack = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();
    chk("t6_idle_regrant", 64'(got_q.size() == 1 ? got_q[0] : -1), 64'(1));

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      wb_rst   = ($urandom_range(0, 63) == 0);
      i_m0_cyc = ($urandom_range(0, 3) != 0);
      i_m1_cyc = ($urandom_range(0, 3) != 0);
      i_m0_adr = $urandom; i_m0_dat = $urandom; i_m0_sel = 4'($urandom); i_m0_we = 1'($urandom);
      i_m1_adr = $urandom; i_m1_dat = $urandom; i_m1_sel = 4'($urandom); i_m1_we = 1'($urandom);
      i_s_ack  = ($urandom_range(0, 3) == 0);
      i_s_rdt  = $urandom;
      tick();
    end
    wb_rst = 1'b0;
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
